// File: rtl/mem_arbiter_if.sv
// Bundle of accessor-side and memory-side signals for the memory arbiter.
// The arbiter takes the slave view; requesters and the memory model take the master view.
interface mem_arbiter_if #(
    parameter int N_ACCESSORS = 2,
    parameter int BITSIZE     = 32
);
    // Accessor side: a request is held until its done pulse.
    // acc_done_o pulses for one cycle, and acc_err_o pulses with it on a timeout.
    logic [N_ACCESSORS-1:0]         acc_req_i;
    logic [N_ACCESSORS-1:0]         acc_write_i;
    logic [2*N_ACCESSORS-1:0]       acc_write_size_i;
    logic [BITSIZE*N_ACCESSORS-1:0] acc_address_i;
    logic [BITSIZE*N_ACCESSORS-1:0] acc_data_i;
    logic [BITSIZE*N_ACCESSORS-1:0] acc_data_o;
    logic [N_ACCESSORS-1:0]         acc_done_o;
    logic [N_ACCESSORS-1:0]         acc_err_o;

    // Memory side: valid/ready style handshake. mem_valid_o rises with a stable
    // address/data/write/size and holds them stable. A transfer completes on the
    // first rising edge where mem_valid_o and mem_valid_i are both 1. The memory
    // may assert mem_valid_i at any time; it is ignored unless mem_valid_o is high.
    logic [BITSIZE-1:0]             mem_addr_o;
    logic [BITSIZE-1:0]             mem_data_o;
    logic [BITSIZE-1:0]             mem_data_i;
    logic                           mem_write_o;
    logic                           mem_valid_o;
    logic [1:0]                     mem_write_size_o;
    logic                           mem_valid_i;

    modport slave (
        input  acc_req_i, acc_write_i, acc_write_size_i, acc_address_i, acc_data_i,
        output acc_data_o, acc_done_o, acc_err_o,
        output mem_addr_o, mem_data_o, mem_write_o, mem_valid_o, mem_write_size_o,
        input  mem_data_i, mem_valid_i
    );

    modport master (
        output acc_req_i, acc_write_i, acc_write_size_i, acc_address_i, acc_data_i,
        input  acc_data_o, acc_done_o, acc_err_o,
        input  mem_addr_o, mem_data_o, mem_write_o, mem_valid_o, mem_write_size_o,
        output mem_data_i, mem_valid_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between N_ACCESSORS requesters.
// One transaction at a time: IDLE grants, ACCESS waits for mem_valid_i (or the
// timeout), and RESP pulses done/err before returning to IDLE. All outputs are registered.
module mem_arbiter #(
    parameter int N_ACCESSORS = 2,
    parameter int BITSIZE     = 32,
    parameter int TIMEOUT     = 16
) (
    input  logic         clk,
    input  logic         rst_i,
    mem_arbiter_if.slave bus,
    output logic [1:0]   state_o
);
    localparam int IDX_W = (N_ACCESSORS > 1) ? $clog2(N_ACCESSORS) : 1;
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               gnt_q, gnt_d;
    logic [IDX_W-1:0]               last_q, last_d;
    logic [7:0]                     wait_q, wait_d;
    logic                           timed_out_q, timed_out_d;
    logic [BITSIZE-1:0]             mem_addr_q, mem_addr_d;
    logic [BITSIZE-1:0]             mem_data_q, mem_data_d;
    logic                           mem_write_q, mem_write_d;
    logic                           mem_valid_q, mem_valid_d;
    logic [1:0]                     mem_size_q, mem_size_d;
    logic [BITSIZE*N_ACCESSORS-1:0] acc_data_q, acc_data_d;
    logic [N_ACCESSORS-1:0]         done_q, done_d;
    logic [N_ACCESSORS-1:0]         err_q, err_d;

    logic                           pick_found;
    logic [IDX_W-1:0]               pick_idx;
    int                             cand;

    // Round-robin pick: first pending request at or after last_granted+1 (wrapping).
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int i = 0; i < N_ACCESSORS; i++) begin
            cand = (int'(last_q) + 1 + i) % N_ACCESSORS;
            if (!pick_found && bus.acc_req_i[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_W-1:0];
            end
        end
    end

    // Next-state and registered-output logic for the IDLE/ACCESS/RESP sequence.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        wait_d      = wait_q;
        timed_out_d = timed_out_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_write_d = mem_write_q;
        mem_valid_d = mem_valid_q;
        mem_size_d  = mem_size_q;
        acc_data_d  = acc_data_q;
        done_d      = '0;
        err_d       = '0;

        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d       = pick_idx;
                    mem_addr_d  = bus.acc_address_i[int'(pick_idx)*BITSIZE +: BITSIZE];
                    mem_data_d  = bus.acc_data_i[int'(pick_idx)*BITSIZE +: BITSIZE];
                    mem_write_d = bus.acc_write_i[pick_idx];
                    mem_size_d  = bus.acc_write_size_i[int'(pick_idx)*2 +: 2];
                    mem_valid_d = 1'b1;
                    wait_d      = 8'd0;
                    timed_out_d = 1'b0;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.mem_valid_i) begin
                    // Read data lands only in the granted slice; writes leave it untouched.
                    if (!mem_write_q) begin
                        acc_data_d[int'(gnt_q)*BITSIZE +: BITSIZE] = bus.mem_data_i;
                    end
                    mem_valid_d = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = RESP;
                end else if (wait_q == TIMEOUT_M1) begin
                    // Give up: mem_valid_o has now been high for TIMEOUT cycles.
                    mem_valid_d = 1'b0;
                    mem_write_d = 1'b0;
                    timed_out_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            RESP: begin
                done_d[gnt_q] = 1'b1;
                err_d[gnt_q]  = timed_out_q;
                last_d        = gnt_q;
                wait_d        = 8'd0;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            last_q      <= IDX_W'(N_ACCESSORS - 1);
            wait_q      <= 8'd0;
            timed_out_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_write_q <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_size_q  <= 2'b00;
            acc_data_q  <= '0;
            done_q      <= '0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            wait_q      <= wait_d;
            timed_out_q <= timed_out_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_write_q <= mem_write_d;
            mem_valid_q <= mem_valid_d;
            mem_size_q  <= mem_size_d;
            acc_data_q  <= acc_data_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.mem_addr_o       = mem_addr_q;
    assign bus.mem_data_o       = mem_data_q;
    assign bus.mem_write_o      = mem_write_q;
    assign bus.mem_valid_o      = mem_valid_q;
    assign bus.mem_write_size_o = mem_size_q;
    assign bus.acc_data_o       = acc_data_q;
    assign bus.acc_done_o       = done_q;
    assign bus.acc_err_o        = err_q;
    assign state_o              = state_q;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter N_ACCESSORS, default 2, number of requesters sharing one memory port.
REQ-002 SHALL have parameter BITSIZE, default 32, data and address width.
REQ-003 SHALL have parameter TIMEOUT, default 16, max cycles waiting for mem_valid_i (1..255).
REQ-004 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port acc_req_i, input, N_ACCESSORS, per-accessor request, held until its done.
REQ-007 SHALL have port acc_write_i, input, N_ACCESSORS, 1 = write, 0 = read, valid with req.
REQ-008 SHALL have port acc_write_size_i, input, 2*N_ACCESSORS, packed write size per accessor.
REQ-009 SHALL have port acc_address_i, input, BITSIZE*N_ACCESSORS, packed addresses, slice k = accessor k.
REQ-010 SHALL have port acc_data_i, input, BITSIZE*N_ACCESSORS, packed write data.
REQ-011 SHALL have port acc_data_o, output, BITSIZE*N_ACCESSORS, packed read data, per-slice registered.
REQ-012 SHALL have port acc_done_o, output, N_ACCESSORS, one-cycle completion pulse.
REQ-013 SHALL have port acc_err_o, output, N_ACCESSORS, one-cycle timeout pulse, coincident with done.
REQ-014 SHALL have ports mem_addr_o, mem_data_o (output, BITSIZE), mem_data_i (input, BITSIZE), mem_write_o, mem_valid_o (output, 1), mem_write_size_o (output, 2), mem_valid_i (input, 1).

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; all outputs registered.
REQ-016 IDLE: if any acc_req_i bit set, SHALL grant exactly one accessor, latch its addr/data/write/size into mem_* registers, go ACCESS; else stay IDLE.
REQ-017 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod N_ACCESSORS; no read/write preference.
REQ-018 ACCESS: mem_valid_o SHALL be 1 and mem_* SHALL hold stable every cycle until mem_valid_i sampled 1.
REQ-019 On mem_valid_i=1 in ACCESS: SHALL capture mem_data_i into granted slice of acc_data_o (reads only), drop mem_valid_o, go RESP.
REQ-020 RESP: SHALL pulse acc_done_o[granted] for exactly one cycle, update last_granted, return to IDLE.
REQ-021 Minimum latency: req sampled at edge E -> mem_valid_o high after E; mem_valid_i seen at E+1 -> done high for cycle after E+2; next grant at earliest E+3.
REQ-022 Wait counter SHALL count cycles in ACCESS; on reaching TIMEOUT without mem_valid_i SHALL drop mem_valid_o, go RESP, pulse done and err together; acc_data_o slice unchanged.
REQ-023 Non-granted acc_data_o slices SHALL never change; done/err bits of non-granted accessors SHALL stay 0.
REQ-024 Request deasserted during ACCESS SHALL NOT abort: transaction completes and done still pulses.
REQ-025 Request inputs changing during ACCESS SHALL NOT affect latched mem_* values.
REQ-026 mem_valid_i while IDLE or RESP SHALL be ignored.
REQ-027 mem_write_o SHALL equal latched write flag during ACCESS, 0 otherwise; mem_write_size_o meaningful only for writes.
REQ-028 Same accessor re-requesting immediately after done SHALL lose to any other pending requester.

Reset
REQ-029 When rst_i sampled 1, SHALL go IDLE at that edge, regardless of state (incl. mid-ACCESS).
REQ-030 Reset values: mem_valid_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, mem_write_size_o=0, acc_done_o=0, acc_err_o=0, acc_data_o=0, wait counter=0, last_granted=N_ACCESSORS-1 (accessor 0 wins first).
REQ-031 Transaction interrupted by reset SHALL produce no done or err pulse.

Verification
REQ-032 Read: acc_req_i=01, write=0, addr0=0x100; mem returns 0xDEADBEEF with mem_valid_i one cycle after valid -> acc_data_o[31:0]=0xDEADBEEF, acc_done_o=01 one cycle, err=0.
REQ-033 Contention: acc_req_i=11 held after reset -> grants 0,1,0,1 alternate; each done single-cycle; no overlap of mem_valid_o transactions.
REQ-034 Write: accessor 1, addr 0x40, data 0x12345678, size 2'b10 -> mem_write_o=1, mem_addr_o=0x40, mem_data_o=0x12345678, mem_write_size_o=2'b10 stable until mem_valid_i; acc_done_o=10.
REQ-035 Timeout: TIMEOUT=4, mem_valid_i tied 0 -> mem_valid_o high exactly 4 cycles, then acc_done_o and acc_err_o both pulse for granted accessor.
REQ-036 Reset mid-access: rst_i=1 for one cycle during ACCESS -> mem_valid_o=0 next cycle, no done; new request after reset granted to accessor 0.
REQ-037 Stall: mem_valid_i delayed 7 cycles, req dropped after 2 -> mem_* stable all 7 cycles, done still pulses.
